sequential_16bit_en: RTL and testbench

- Golden user design for the fabric regression: a 16-bit synchronous up-counter with enable, driven through a 28-bit generic I/O bus.
- Runs in lock-step with the eFPGA fabric configured from the same design's bitstream.
- Outputs are compared every cycle against the fabric's I_top, and ~io_oeb is compared against the fabric's T_top.
- Purely synchronous, single clock domain.

---
 rtl/sequential_16bit_en_pkg.sv | 51 +++++
 rtl/sequential_16bit_en_en_counter.sv | 52 +++++
 rtl/sequential_16bit_en.sv | 48 ++++
 tb/tb_sequential_16bit_en.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sequential_16bit_en_pkg.sv
// -----------------------------------------------------------------------------
// sequential_16bit_en_pkg
//
// Purpose:
//   Shared constants and helpers for the sequential_16bit_en golden design.
//   The design is a 16-bit up-counter with enable, reached through a 28-bit
//   generic pad bus. This package fixes the pad layout so that the top level
//   and the counter agree on widths and bit positions.
//
// Contents:
//   IO_WIDTH   - width of the io_in / io_out / io_oeb pad buses
//   CTR_WIDTH  - counter width in bits
//   CTR_LSB    - pad index of the counter LSB on io_out
//   RST_BIT    - pad index of the synchronous active-high reset on io_in
//   EN_BIT     - pad index of the count enable on io_in
//   OEB_CONST  - fixed output-enable-bar pattern (rst/en pads are inputs)
//   pad_ctrl_t - decoded control pads
//   decode_pads() / pack_io_out() - pad split and pack helpers
// -----------------------------------------------------------------------------
package sequential_16bit_en_pkg;

  localparam int unsigned IO_WIDTH  = 28;
  localparam int unsigned CTR_WIDTH = 16;
  localparam int unsigned CTR_LSB   = 12;

  localparam int unsigned RST_BIT = 0;
  localparam int unsigned EN_BIT  = 1;

  // Pads 0 and 1 are inputs (oeb = 1); every other pad is a driven output.
  localparam logic [IO_WIDTH-1:0] OEB_CONST = 28'h0000003;

  // Decoded control inputs taken from the pad bus.
  typedef struct packed {
    logic rst;
    logic en;
  } pad_ctrl_t;

  // Pull the two control pads out of the input bus; all other pads are ignored.
  function automatic pad_ctrl_t decode_pads(input logic [IO_WIDTH-1:0] pads);
    pad_ctrl_t ctrl;
    ctrl.rst = pads[RST_BIT];
    ctrl.en  = pads[EN_BIT];
    return ctrl;
  endfunction

  // Place the counter in the top bits of the output bus; the low pads stay 0.
  function automatic logic [IO_WIDTH-1:0] pack_io_out(input logic [CTR_WIDTH-1:0] ctr);
    return {ctr, {CTR_LSB{1'b0}}};
  endfunction

endpackage : sequential_16bit_en_pkg

// File: rtl/sequential_16bit_en_en_counter.sv
// -----------------------------------------------------------------------------
// en_counter
//
// Purpose:
//   WIDTH-bit synchronous up-counter with synchronous active-high reset and
//   count enable. Reset has priority over enable. The count wraps modulo
//   2^WIDTH with no carry-out. The count output comes straight from the
//   register, so there is no combinational path from the inputs.
//
// Ports:
//   clk_i   - clock; all state changes on its rising edge
//   rst_i   - synchronous active-high reset (clears the count)
//   en_i    - count enable (increment when high, hold when low)
//   count_o - current registered count
// -----------------------------------------------------------------------------
module en_counter
  import sequential_16bit_en_pkg::*;
#(
  parameter int unsigned WIDTH = CTR_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-count selection: increment when enabled, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      // Plain WIDTH-bit addition gives the modulo wrap from all-ones to zero.
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset taking priority over enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : en_counter

// File: rtl/sequential_16bit_en.sv
// -----------------------------------------------------------------------------
// sequential_16bit_en
//
// Purpose:
//   Golden user design for fabric regression: a 16-bit enabled up-counter
//   exposed on a 28-bit generic pad bus. This level only maps pads: it splits
//   io_in into reset/enable, packs the count into io_out and ties io_oeb.
//
// Ports:
//   clk    - system clock
//   io_in  - [0] synchronous active-high reset, [1] count enable,
//            [27:2] unused
//   io_out - [27:12] counter value, [11:0] constant 0
//   io_oeb - constant 28'h0000003 (pads 0/1 are inputs, the rest outputs)
// -----------------------------------------------------------------------------
module sequential_16bit_en
  import sequential_16bit_en_pkg::*;
(
  input  logic                clk,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oeb
);

  pad_ctrl_t            ctrl_s;
  logic [CTR_WIDTH-1:0] ctr_s;

  // Pads above the enable are genuinely don't-care; fold them into a single
  // deliberately unused net so they are visibly consumed.
  logic                 unused_io_in;

  assign ctrl_s       = decode_pads(io_in);
  assign unused_io_in = ^io_in[IO_WIDTH-1:EN_BIT+1];

  en_counter #(
    .WIDTH (CTR_WIDTH)
  ) u_en_counter (
    .clk_i   (clk),
    .rst_i   (ctrl_s.rst),
    .en_i    (ctrl_s.en),
    .count_o (ctr_s)
  );

  // The count is already registered, so io_out has no path from io_in.
  assign io_out = pack_io_out(ctr_s);
  assign io_oeb = OEB_CONST;

endmodule : sequential_16bit_en

// File: tb/tb_sequential_16bit_en.sv
// -----------------------------------------------------------------------------
// tb_sequential_16bit_en
//
// Self-checking bench for sequential_16bit_en: a vector table, directed
// sequences for hold / wrap / reset priority / unused pads, and a randomized
// run against a counting reference model.
// -----------------------------------------------------------------------------
module tb_sequential_16bit_en;

  logic        clk;
  logic [27:0] io_in;
  logic [27:0] io_out;
  logic [27:0] io_oeb;

  int checks;
  int failures;

  // Reference count: a plain integer kept in 0..65535.
  int model_ctr;

  typedef struct {
    logic [27:0] stim;
    logic [27:0] exp_out;
  } vec_t;

  vec_t vecs [0:13];

  sequential_16bit_en dut (
    .clk    (clk),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one input value across one rising edge; outputs are then read at
  // the following falling edge. The reference model advances by the rules.
  task automatic step(input logic [27:0] v);
    io_in = v;
    @(posedge clk);
    @(negedge clk);
    if (v[0]) model_ctr = 0;
    else if (v[1]) model_ctr = (model_ctr + 1) % 65536;
  endtask

  function automatic logic [27:0] model_out();
    return 28'(model_ctr * 4096);
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    model_ctr = 0;
    io_in     = 28'h0000003;

    // Reset: rst=1, en=1 for 5 edges.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step(28'h0000003);
      check("reset_out", io_out, 28'h0000000);
      check("reset_oeb", io_oeb, 28'h0000003);
    end

    // Table of single-edge vectors, continuing from a cleared counter.
    vecs[0]  = '{28'h0000002, 28'h0001000};
    vecs[1]  = '{28'h0000002, 28'h0002000};
    vecs[2]  = '{28'h0000000, 28'h0002000};
    vecs[3]  = '{28'hFFFFFFC, 28'h0002000};
    vecs[4]  = '{28'h0000002, 28'h0003000};
    vecs[5]  = '{28'h0000003, 28'h0000000};
    vecs[6]  = '{28'h0000002, 28'h0001000};
    vecs[7]  = '{28'hABCDEF2, 28'h0002000};
    vecs[8]  = '{28'h0000001, 28'h0000000};
    vecs[9]  = '{28'h0000000, 28'h0000000};
    vecs[10] = '{28'h5555556, 28'h0001000};
    vecs[11] = '{28'hFFFFFFF, 28'h0000000};
    vecs[12] = '{28'h0000006, 28'h0001000};
    vecs[13] = '{28'h0000002, 28'h0002000};
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].stim);
      check($sformatf("vec%0d_out", i), io_out, vecs[i].exp_out);
      check($sformatf("vec%0d_oeb", i), io_oeb, 28'h0000003);
    end

    // Count: 100 cycles of en=1 from zero.
    step(28'h0000003);
    for (int i = 1; i <= 100; i++) begin
      step(28'h0000002);
      check("count_ctr", {12'h000, io_out[27:12]}, 28'(i));
      check("count_low", {16'h0000, io_out[11:0]}, 28'h0000000);
      check("count_oeb", io_oeb, 28'h0000003);
    end

    // Hold at 0x0010 for 10 edges, then resume.
    step(28'h0000003);
    for (int i = 0; i < 16; i++) step(28'h0000002);
    check("hold_start", io_out, 28'h0010000);
    for (int i = 0; i < 10; i++) begin
      step(28'h0000000);
      check("hold", io_out, 28'h0010000);
    end
    step(28'h0000002);
    check("hold_resume", io_out, 28'h0011000);

    // Reset mid-count at 0x1234, then resume from 0.
    step(28'h0000003);
    for (int i = 0; i < 32'h1234; i++) step(28'h0000002);
    check("mid_at_1234", io_out, 28'h1234000);
    step(28'h0000003);
    check("mid_reset", io_out, 28'h0000000);
    step(28'h0000002);
    check("mid_resume", io_out, 28'h0001000);

    // Wrap: count up to 0xFFFF, then over the top.
    step(28'h0000003);
    for (int i = 0; i < 65535; i++) step(28'h0000002);
    check("wrap_ffff", io_out, 28'hFFFF000);
    step(28'h0000002);
    check("wrap_zero", io_out, 28'h0000000);
    step(28'h0000002);
    check("wrap_one", io_out, 28'h0001000);

    // Unused pads toggled with en=0, rst=0: nothing changes.
    for (int i = 0; i < 20; i++) begin
      step({26'($urandom), 2'b00});
      check("unused_out", io_out, 28'h0001000);
      check("unused_oeb", io_oeb, 28'h0000003);
    end

    // Randomized run against the reference model; reset kept rare.
    for (int i = 0; i < 500; i++) begin
      logic [27:0] v;
      v    = 28'($urandom);
      v[0] = ($urandom_range(0, 15) == 0);
      step(v);
      check("rand_out", io_out, model_out());
      check("rand_oeb", io_oeb, 28'h0000003);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sequential_16bit_en
